// File: rtl/calc_pkg.sv
// calc_pkg: shared state, operator and display-source codes for the calculator controller
package calc_pkg;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_IN_A   = 3'd1;
  localparam logic [2:0] S_SEL_OP = 3'd2;
  localparam logic [2:0] S_IN_B   = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_SHOW   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;
  localparam logic [1:0] DISP_ENTRY = 2'd0;
  localparam logic [1:0] DISP_OP    = 2'd1;
  localparam logic [1:0] DISP_RES   = 2'd2;
  localparam logic [1:0] DISP_ERR   = 2'd3;
  // display source shown while the FSM sits in state s
  function automatic logic [1:0] disp_of(input logic [2:0] s);
    return (s == S_SEL_OP) ? DISP_OP :
           (s == S_EXEC || s == S_SHOW) ? DISP_RES :
           (s == S_ERR) ? DISP_ERR : DISP_ENTRY;
  endfunction
endpackage

// File: rtl/calc_timeout.sv
// calc_timeout: ALU watchdog, flags the LIMIT-th consecutive enabled cycle
module calc_timeout #(
  parameter int LIMIT = 255
) (
  input  logic clk_db,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  logic [W-1:0] cnt;
  assign expired = en && (cnt == LAST);
  // count enabled cycles, hold once expired until cleared
  always_ff @(posedge clk_db or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/calc_ctrl.sv
// calc_ctrl: calculator sequencing FSM; define CALC_CHAIN_EN to allow chaining a shown result into operand A
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int ALU_TIMEOUT = 255
) (
  input  logic        clk_db,
  input  logic        rst_n,
  input  logic        btn_start,
  input  logic        btn_clear,
  input  logic        btn_confirm,
  input  logic [1:0]  sw_op,
  input  logic        input_done,
  input  logic [31:0] number,
  input  logic        is_negative,
  input  logic        alu_done,
  input  logic        alu_err,
  input  logic [31:0] alu_result,
  output logic        start_input,
  output logic        alu_start,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic        neg_a,
  output logic        neg_b,
  output logic [1:0]  op_sel,
  output logic [31:0] result,
  output logic        err,
  output logic [2:0]  state,
  output logic [1:0]  disp_sel
);
`ifdef CALC_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif
  logic [2:0] nxt;
  logic       div_zero, expired, launch;
  assign div_zero = (op_sel == OP_DIV) && (operand_b == '0);
  assign launch   = (state == S_IN_B) && (nxt == S_EXEC) && !((op_sel == OP_DIV) && (number == '0));
  calc_timeout #(.LIMIT(ALU_TIMEOUT)) u_timeout (
    .clk_db  (clk_db),
    .rst_n   (rst_n),
    .clr     (btn_clear || state != S_EXEC),
    .en      (state == S_EXEC),
    .expired (expired)
  );
  // next state; clear overrides everything, stray done pulses fall through to hold
  always_comb begin
    nxt = state;
    if (btn_clear) nxt = S_IDLE;
    else case (state)
      S_IDLE:   nxt = btn_start ? S_IN_A : S_IDLE;
      S_IN_A:   nxt = input_done ? S_SEL_OP : S_IN_A;
      S_SEL_OP: nxt = btn_confirm ? S_IN_B : S_SEL_OP;
      S_IN_B:   nxt = input_done ? S_EXEC : S_IN_B;
      S_EXEC:   nxt = (div_zero || (alu_done ? alu_err : expired)) ? S_ERR : alu_done ? S_SHOW : S_EXEC;
      S_SHOW:   nxt = btn_start ? S_IN_A : (CHAIN && btn_confirm) ? S_SEL_OP : S_SHOW;
      S_ERR:    nxt = btn_start ? S_IN_A : S_ERR;
      default:  nxt = S_IDLE;
    endcase
  end
  // registered outputs and operand/result latches keyed off the chosen transition
  always_ff @(posedge clk_db or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      start_input <= 1'b0;
      alu_start   <= 1'b0;
      err         <= 1'b0;
      disp_sel    <= DISP_ENTRY;
      operand_a   <= '0;
      operand_b   <= '0;
      neg_a       <= 1'b0;
      neg_b       <= 1'b0;
      op_sel      <= OP_ADD;
      result      <= '0;
    end else begin
      state       <= nxt;
      start_input <= (nxt == S_IN_A || nxt == S_IN_B) && nxt != state;
      alu_start   <= launch;
      err         <= nxt == S_ERR;
      disp_sel    <= disp_of(nxt);
      if (state == S_IN_A && nxt == S_SEL_OP) begin
        operand_a <= number;
        neg_a     <= is_negative;
      end
      if (state == S_SHOW && nxt == S_SEL_OP) begin
        operand_a <= result;
        neg_a     <= result[31];
      end
      if (state == S_SEL_OP && !btn_clear) op_sel <= sw_op;
      if (state == S_IN_B && nxt == S_EXEC) begin
        operand_b <= number;
        neg_b     <= is_negative;
      end
      if (state == S_EXEC && nxt == S_SHOW) result <= alu_result;
    end
  end
endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: randomized transaction-level check of calc_ctrl against expected outcomes per calculation
module tb_calc_ctrl;
  localparam int T = 8;
  localparam logic [2:0] IDLE = 3'd0, IN_A = 3'd1, SEL_OP = 3'd2, IN_B = 3'd3, EXEC = 3'd4, SHOW = 3'd5, ERRS = 3'd6;
  logic        clk_db = 1'b0;
  logic        rst_n;
  logic        btn_start, btn_clear, btn_confirm, input_done, is_negative, alu_done, alu_err;
  logic [1:0]  sw_op;
  logic [31:0] number, alu_result;
  logic        start_input, alu_start, neg_a, neg_b, err;
  logic [31:0] operand_a, operand_b, result;
  logic [1:0]  op_sel, disp_sel;
  logic [2:0]  state;
  int n_chk = 0, n_err = 0, n_si = 0, n_as = 0;
  logic [31:0] m_a, m_b, m_res;
  logic        m_na, m_nb;

  calc_ctrl #(.ALU_TIMEOUT(T)) dut (
    .clk_db(clk_db), .rst_n(rst_n), .btn_start(btn_start), .btn_clear(btn_clear),
    .btn_confirm(btn_confirm), .sw_op(sw_op), .input_done(input_done), .number(number),
    .is_negative(is_negative), .alu_done(alu_done), .alu_err(alu_err), .alu_result(alu_result),
    .start_input(start_input), .alu_start(alu_start), .operand_a(operand_a), .operand_b(operand_b),
    .neg_a(neg_a), .neg_b(neg_b), .op_sel(op_sel), .result(result), .err(err), .state(state),
    .disp_sel(disp_sel)
  );

  always #5 clk_db = ~clk_db;

  always @(negedge clk_db) begin
    if (start_input) n_si++;
    if (alu_start) n_as++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_db);
    #1;
  endtask

  task automatic check_held(input string tag);
    check({tag, " operand_a"}, operand_a, m_a);
    check({tag, " neg_a"}, neg_a, m_na);
    check({tag, " operand_b"}, operand_b, m_b);
    check({tag, " result"}, result, m_res);
  endtask

  task automatic do_clear;
    btn_clear = 1; tick(); btn_clear = 0;
    check("clear state", state, IDLE);
    check("clear err", err, 0);
    check("clear disp", disp_sel, 0);
    check_held("clear");
  endtask

  // one full calculation; dly = EXEC cycle index at which alu_done arrives, -1 for never
  task automatic run_calc(input logic [31:0] a, input logic na, input logic [1:0] op,
                          input logic [31:0] b, input logic nb, input int dly,
                          input logic aerr, input logic [31:0] res);
    int si0, as0, xc;
    logic div0, show, consumed;
    logic [1:0] junk;
    si0 = n_si; as0 = n_as;
    div0 = (op == 2'd3) && (b == 0);
    consumed = !div0 && dly >= 0 && dly < T;
    show = consumed && !aerr;
    btn_start = 1; tick(); btn_start = 0;
    check("start state", state, IN_A);
    check("start disp", disp_sel, 0);
    if ($urandom_range(1) == 1) begin
      alu_done = 1; alu_result = $urandom; tick(); alu_done = 0;
      check("stray alu_done", state, IN_A);
    end
    number = a; is_negative = na; input_done = 1; tick(); input_done = 0;
    m_a = a; m_na = na;
    check("a state", state, SEL_OP);
    check("a disp", disp_sel, 1);
    check_held("a latch");
    junk = 2'($urandom); sw_op = junk; tick();
    check("op track", op_sel, junk);
    if ($urandom_range(1) == 1) begin
      number = $urandom; input_done = 1; tick(); input_done = 0;
      check("stray input_done", operand_a, m_a);
    end
    sw_op = op; btn_confirm = 1; tick(); btn_confirm = 0; sw_op = ~op;
    check("confirm state", state, IN_B);
    check("confirm op", op_sel, op);
    tick();
    check("op frozen", op_sel, op);
    number = b; is_negative = nb; input_done = 1; tick(); input_done = 0;
    m_b = b; m_nb = nb;
    check("b latch", operand_b, b);
    check("b neg", neg_b, nb);
    xc = 0;
    for (int k = 0; k < T + 4 && state == EXEC; k++) begin
      xc++;
      if (k == dly) begin alu_done = 1; alu_err = aerr; alu_result = res; end
      tick();
      alu_done = 0; alu_err = 0;
    end
    if (show) m_res = res;
    if (div0) check("div0 latency", xc <= 1, 1);
    else check("exec cycles", xc, consumed ? dly + 1 : T);
    check("end state", state, show ? SHOW : ERRS);
    check("end err", err, !show);
    check("end disp", disp_sel, show ? 2 : 3);
    check("alu_start pulses", n_as - as0, div0 ? 0 : 1);
    check("start_input pulses", n_si - si0, 2);
    check_held("end");
    if (!show) begin
      alu_done = 1; alu_result = $urandom; btn_confirm = 1; input_done = 1; tick();
      alu_done = 0; btn_confirm = 0; input_done = 0;
      check("err sticky", state, ERRS);
      check("err sticky result", result, m_res);
    end
  endtask

  initial begin
    rst_n = 0; btn_start = 0; btn_clear = 0; btn_confirm = 0; sw_op = 0; input_done = 0;
    number = 0; is_negative = 0; alu_done = 0; alu_err = 0; alu_result = 0;
    m_a = 0; m_b = 0; m_res = 0; m_na = 0; m_nb = 0;
    repeat (3) tick();
    check("rst state", state, IDLE);
    check("rst op_sel", op_sel, 0);
    check("rst err", err, 0);
    check("rst start_input", start_input, 0);
    check("rst alu_start", alu_start, 0);
    check_held("rst");
    @(negedge clk_db); rst_n = 1;
    tick();

    run_calc(32'd125000, 0, 2'd0, 32'd30000, 0, 2, 0, 32'd155000);
    check("add result", result, 32'd155000);
    btn_confirm = 1; tick(); btn_confirm = 0;
`ifdef CALC_CHAIN_EN
    m_a = 32'd155000; m_na = 0;
    check("chain state", state, SEL_OP);
    check("chain operand_a", operand_a, 32'd155000);
    check("chain neg_a", neg_a, 0);
    do_clear();
`else
    check("nochain state", state, SHOW);
    check("nochain operand_a", operand_a, 32'd125000);
`endif

    run_calc(32'd70000, 1, 2'd3, 32'd0, 0, 0, 0, 32'd1);
    run_calc(32'd10000, 0, 2'd2, 32'd20000, 1, -1, 0, 32'd5);
    do_clear();

    btn_start = 1; tick(); btn_start = 0;
    number = 32'd999; input_done = 1; btn_clear = 1; tick(); input_done = 0; btn_clear = 0;
    check("clr prio state", state, IDLE);
    check("clr prio operand_a", operand_a, m_a);

    run_calc(32'd50000, 0, 2'd1, 32'd40000, 0, 1, 1, 32'd7);

    btn_start = 1; tick(); btn_start = 0;
    number = 32'd11; input_done = 1; tick(); input_done = 0;
    sw_op = 2'd0; btn_confirm = 1; tick(); btn_confirm = 0;
    number = 32'd22; input_done = 1; tick(); input_done = 0;
    check("pre-rst state", state, EXEC);
    #2 rst_n = 0; #1;
    m_a = 0; m_na = 0; m_b = 0; m_nb = 0; m_res = 0;
    check("async rst state", state, IDLE);
    check("async rst alu_start", alu_start, 0);
    check("async rst disp", disp_sel, 0);
    check_held("async rst");
    @(negedge clk_db); rst_n = 1;
    tick();
    alu_done = 1; alu_result = 32'd12345; tick(); alu_done = 0;
    check("post-rst alu_done state", state, IDLE);
    check("post-rst result", result, 0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] b;
      int dly;
      b = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
      dly = ($urandom_range(3) == 0) ? -1 : int'($urandom_range(T + 2));
      run_calc($urandom, 1'($urandom), 2'($urandom), b, 1'($urandom), dly,
               $urandom_range(4) == 0, $urandom);
      if ($urandom_range(2) == 0) do_clear();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
